// File: rtl/de_hazard_scheduler.sv
// Stall/flush scheduler for the PC/F->D and D->E pipeline registers.
// Tracks Tnew of the writers in E and M plus the mult/div busy counter against D-stage Tuse.
module de_hazard_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic       use_rs_D,
  input  logic       use_rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic [4:0] a3_D,
  input  logic       wen_D,
  input  logic [1:0] tnew_D,
  input  logic       md_use_D,
  input  logic       md_start_E,
  input  logic       md_is_div_E,
  input  logic       exc_flush,
  output logic       en_PC,
  output logic       en_D,
  output logic       clr_D,
  output logic       clr_E,
  output logic       stall,
  output logic       md_busy
);

  logic             v_e_q, v_e_d, v_m_q, v_m_d;
  logic [4:0]       a3_e_q, a3_e_d, a3_m_q, a3_m_d;
  logic [1:0]       tn_e_q, tn_e_d, tn_m_q, tn_m_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hz_rs, hz_rt, hz_md;

  function automatic logic [1:0] sat_dec_tn(input logic [1:0] tn);
    return (tn == 2'd0) ? 2'd0 : tn - 2'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec_cnt(input logic [CNT_W-1:0] c);
    return (c == '0) ? '0 : c - CNT_W'(1);
  endfunction

  // A source is hazardous only if its producer's result arrives later than it is needed.
  function automatic logic src_hazard(input logic use_src, input logic [4:0] src,
                                      input logic [1:0] tuse,
                                      input logic ve, input logic [4:0] a3e, input logic [1:0] tne,
                                      input logic vm, input logic [4:0] a3m, input logic [1:0] tnm);
    return use_src && (src != 5'd0) &&
           ((ve && (a3e == src) && (tne > tuse)) || (vm && (a3m == src) && (tnm > tuse)));
  endfunction

  always_comb begin
    hz_rs   = src_hazard(use_rs_D, rs_D, tuse_rs_D, v_e_q, a3_e_q, tn_e_q, v_m_q, a3_m_q, tn_m_q);
    hz_rt   = src_hazard(use_rt_D, rt_D, tuse_rt_D, v_e_q, a3_e_q, tn_e_q, v_m_q, a3_m_q, tn_m_q);
    hz_md   = md_use_D && (md_start_E || (cnt_q != '0));
    stall   = (hz_rs || hz_rt || hz_md) && !exc_flush && !reset;
    en_PC   = !stall;
    en_D    = !stall;
    clr_E   = stall || exc_flush;
    clr_D   = exc_flush;
    md_busy = (cnt_q != '0);
  end

  always_comb begin
    v_e_d  = v_e_q;
    a3_e_d = a3_e_q;
    tn_e_d = tn_e_q;
    v_m_d  = v_m_q;
    a3_m_d = a3_m_q;
    tn_m_d = tn_m_q;
    cnt_d  = sat_dec_cnt(cnt_q);
    if (exc_flush) begin
      // Flushed instructions never produce results; an md start being flushed never loads.
      v_e_d = 1'b0;
      v_m_d = 1'b0;
    end else begin
      v_m_d  = v_e_q;
      a3_m_d = a3_e_q;
      tn_m_d = sat_dec_tn(tn_e_q);
      v_e_d  = !stall && wen_D && (a3_D != 5'd0);
      a3_e_d = a3_D;
      tn_e_d = tnew_D;
      if (md_start_E)
        cnt_d = md_is_div_E ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_e_q  <= 1'b0;
      a3_e_q <= 5'd0;
      tn_e_q <= 2'd0;
      v_m_q  <= 1'b0;
      a3_m_q <= 5'd0;
      tn_m_q <= 2'd0;
      cnt_q  <= '0;
    end else begin
      v_e_q  <= v_e_d;
      a3_e_q <= a3_e_d;
      tn_e_q <= tn_e_d;
      v_m_q  <= v_m_d;
      a3_m_q <= a3_m_d;
      tn_m_q <= tn_m_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: doc/de_hazard_scheduler.md
Name: de_hazard_scheduler

Overview:
- Stall/flush scheduler for the D→E pipeline register and the PC/F→D registers.
- Keeps a registered scoreboard of destination register and remaining cycles-to-result (Tnew) for the instructions in E and M.
- Compares that scoreboard with the D-stage instruction's operand needs (Tuse) and with a multiply/divide busy counter.
- Produces the enables and bubble/flush clears that sequence the pipeline, with exception flush taking priority.

Parameters:
- MULT_CYCLES, 5, busy cycles after mult/multu leaves E
- DIV_CYCLES, 10, busy cycles after div/divu leaves E
- CNT_W, 4, width of md busy counter (must hold DIV_CYCLES)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; clears all state
- rs_D  in  5  D-stage source reg 1
- rt_D  in  5  D-stage source reg 2
- use_rs_D  in  1  D instr reads rs
- use_rt_D  in  1  D instr reads rt
- tuse_rs_D  in  2  cycles until rs value needed (0 = in D)
- tuse_rt_D  in  2  cycles until rt value needed
- a3_D  in  5  D instr destination reg
- wen_D  in  1  D instr writes GPR
- tnew_D  in  2  Tnew the instr will have on entering E (ALU 1, load 2, link 0)
- md_use_D  in  1  D instr is mult/div/mfhi/mflo/mthi/mtlo
- md_start_E  in  1  mult/div instr currently in E (one cycle per instr)
- md_is_div_E  in  1  1 = div/divu, 0 = mult/multu
- exc_flush  in  1  exception/interrupt/eret redirect this cycle
- en_PC  out  1  PC write enable
- en_D  out  1  F→D register enable
- clr_D  out  1  F→D register clear
- clr_E  out  1  D→E register clear (bubble)
- stall  out  1  hazard stall indicator
- md_busy  out  1  md counter nonzero

Behaviour:
State:
- E entry {vE, a3E, tnE}
- M entry {vM, a3M, tnM}
- md counter cnt

Hazard terms (combinational):
- hz_rs = use_rs_D & rs_D≠0 & ((vE & a3E==rs_D & tnE>tuse_rs_D) | (vM & a3M==rs_D & tnM>tuse_rs_D))
- hz_rt: same with rt_D / tuse_rt_D.
- hz_md = md_use_D & (md_start_E | cnt≠0)
- stall = (hz_rs | hz_rt | hz_md) & ~exc_flush & ~reset

Outputs (combinational):
- en_PC = en_D = ~stall.
- clr_E = stall | exc_flush.
- clr_D = exc_flush.
- md_busy = (cnt≠0).
- During reset: stall=0, en_PC=en_D=1, clr_D=clr_E=0.
- exc_flush overrides stall: en_PC=1 so the handler fetch proceeds.

Registered update (rising edge):
- reset: vE=vM=0, a3E=a3M=0, tnE=tnM=0, cnt=0.
- exc_flush: vE=vM=0. cnt decrements if nonzero. md_start_E in the same cycle is ignored (no load).
- otherwise:
  - M ← E with tnM = (tnE==0) ? 0 : tnE−1 (saturating); vM = vE.
  - E ← stall ? invalid (vE=0) : {wen_D & a3_D≠0, a3_D, tnew_D}.
  - cnt: if md_start_E → load md_is_div_E ? DIV_CYCLES : MULT_CYCLES; else if cnt≠0 → cnt−1.
- Writes to $0 never enter the scoreboard. An entry with tn==0 never causes a stall (result is forwardable).
- Two entries with the same a3: either one exceeding Tuse stalls.
- md_start_E while cnt≠0 (back-to-back md issue is prevented by hz_md): reload wins.
- Stall latency 0 cycles (same-cycle decision). The bubble appears in E at the next edge.

Test Plan:
- lw $1 enters E (tnew_D=2), next D reads rs=$1 with tuse=1 → stall=1 exactly 1 cycle, clr_E=1, en_PC=en_D=0; then stall=0.
- lw $1 then beq reading $1 (tuse=0) → stall 2 consecutive cycles (E tn=2, then M tn=1), released on 3rd.
- addu $0 then D reads rs=$0, tuse=0 → stall=0 every cycle; scoreboard vE=0.
- mult in E (md_start_E=1, md_is_div_E=0), mflo held in D → stall 6 cycles (start cycle + cnt 5..1); div variant → 11 cycles; md_busy high 5/10 cycles.
- Load-use stall active, exc_flush=1 → same cycle stall=0, en_PC=1, clr_D=clr_E=1; next cycle vE=vM=0, no stall for same D operands.
- reset asserted with cnt=7 and vE=vM=1 → next cycle cnt=0, md_busy=0, stall=0; md_use_D proceeds without stall.
